hazard_fwd_unit: RTL and testbench

- Parametrised next-generation forwarding/hazard unit for the 5-stage pipeline.
- Replaces the purely combinational forwarding logic and adds three things:
  - load-use stall detection;
  - a per-register scoreboard with countdown counters for long-latency (multi-cycle) EX operations;
  - a saturating stall-cycle counter for performance monitoring.
- Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Drives the EX operand muxes, the MEM store-data mux, the PC/IFID hold and the IDEX bubble insertion.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/hazard_fwd_unit_if.sv | 51 +++++
 rtl/hazard_fwd_unit_sb_counter.sv | 30 +++
 rtl/hazard_fwd_unit.sv | 86 ++++++++
 tb/tb_hazard_fwd_unit.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding-select codes, default register
// address width and the register address type.
package pipe_pkg;

    localparam int unsigned AW   = 4;
    // Countdown width of one scoreboard entry; LONG_LAT-1 <= 14 fits.
    localparam int unsigned SB_W = 4;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef logic [AW-1:0] reg_addr_t;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-side view of the hazard/forwarding unit.
//   master : pipeline registers driving the register fields and controls,
//            receiving forwarding selects, stall/bubble and monitor outputs
//   slave  : the hazard/forwarding unit itself
interface hazard_fwd_unit_if #(
    parameter int unsigned AW    = pipe_pkg::AW,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned NREG = 1 << AW;

    logic [AW-1:0]    id_rs;
    logic [AW-1:0]    id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [AW-1:0]    idex_rs;
    logic [AW-1:0]    idex_rt;
    logic [AW-1:0]    idex_rd;
    logic             idex_rw;
    logic             idex_mr;
    logic             idex_long;
    logic             idex_valid;
    logic [AW-1:0]    exmem_rd;
    logic [AW-1:0]    exmem_rt;
    logic             exmem_rw;
    logic             exmem_mw;
    logic [AW-1:0]    memwb_rd;
    logic             memwb_rw;
    logic             flush;
    logic [1:0]       ex_fwd1;
    logic [1:0]       ex_fwd2;
    logic             mem_fwd;
    logic             stall;
    logic             bubble;
    logic [NREG-1:0]  busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
               idex_rs, idex_rt, idex_rd, idex_rw, idex_mr, idex_long, idex_valid,
               exmem_rd, exmem_rt, exmem_rw, exmem_mw, memwb_rd, memwb_rw, flush,
        input  ex_fwd1, ex_fwd2, mem_fwd, stall, bubble, busy, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
               idex_rs, idex_rt, idex_rd, idex_rw, idex_mr, idex_long, idex_valid,
               exmem_rd, exmem_rt, exmem_rw, exmem_mw, memwb_rd, memwb_rw, flush,
        output ex_fwd1, ex_fwd2, mem_fwd, stall, bubble, busy, stall_cnt
    );

endinterface

// File: rtl/hazard_fwd_unit_sb_counter.sv
// One scoreboard entry: countdown until a long-latency result reaches MEM/WB.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : long op issuing to this register (reload beats expiry)
//   load_val   : cycles still pending after the issue edge
//   busy       : counter nonzero, result not yet forwardable
module sb_counter (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [pipe_pkg::SB_W-1:0] load_val,
    output logic                      busy
);
    import pipe_pkg::*;

    logic [SB_W-1:0] cnt;

    // Free-running decrement, independent of stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - SB_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_fwd_unit.sv
// Forwarding, load-use / long-latency hazard detection and stall monitor for
// the 5-stage pipeline.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : pipeline register fields in; EX/MEM forwarding selects,
//                stall/bubble, scoreboard busy bits and stall counter out
module hazard_fwd_unit #(
    parameter int unsigned AW       = pipe_pkg::AW,
    parameter int unsigned LONG_LAT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input logic               clk,
    input logic               rst_n,
    hazard_fwd_unit_if.slave  bus
);
    import pipe_pkg::*;

    localparam int unsigned NREG = 1 << AW;

    logic [1:0]       fwd1;
    logic [1:0]       fwd2;
    logic             mem_fwd_c;
    logic             id_match_c;
    logic             writer_c;
    logic             load_use_c;
    logic             issue_c;
    logic             long_haz_c;
    logic             busy_haz_c;
    logic             stall_c;
    logic [NREG-1:0]  pend;
    logic [CNT_W-1:0] stall_cnt;

    // EX operand selection; EX/MEM assigned last so it overrides MEM/WB
    always_comb begin
        fwd1 = FWD_RF;
        fwd2 = FWD_RF;
        if (bus.memwb_rw && bus.memwb_rd != '0 && bus.memwb_rd == bus.idex_rs) fwd1 = FWD_WB;
        if (bus.memwb_rw && bus.memwb_rd != '0 && bus.memwb_rd == bus.idex_rt) fwd2 = FWD_WB;
        if (bus.exmem_rw && bus.exmem_rd != '0 && bus.exmem_rd == bus.idex_rs) fwd1 = FWD_MEM;
        if (bus.exmem_rw && bus.exmem_rd != '0 && bus.exmem_rd == bus.idex_rt) fwd2 = FWD_MEM;
    end

    assign mem_fwd_c = bus.exmem_mw && bus.memwb_rw && bus.memwb_rd != '0
                       && bus.memwb_rd == bus.exmem_rt;

    // A live, unflushed ID/EX writer of a nonzero register that ID reads
    assign id_match_c = (bus.id_use_rs && bus.id_rs == bus.idex_rd)
                     || (bus.id_use_rt && bus.id_rt == bus.idex_rd);
    assign writer_c   = bus.idex_valid && bus.idex_rw && bus.idex_rd != '0 && !bus.flush;
    assign load_use_c = writer_c && bus.idex_mr && id_match_c;
    assign issue_c    = writer_c && bus.idex_long;
    assign long_haz_c = issue_c && id_match_c;
    // Scoreboard hazard survives flush: the long op is already in flight
    assign busy_haz_c = (bus.id_use_rs && pend[bus.id_rs])
                     || (bus.id_use_rt && pend[bus.id_rt]);
    assign stall_c    = rst_n && (load_use_c || long_haz_c || busy_haz_c);

    // Scoreboard; register 0 never pends
    assign pend[0] = 1'b0;
    for (genvar r = 1; r < NREG; r++) begin : g_sb
        sb_counter u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (issue_c && bus.idex_rd == AW'(r)),
            .load_val (SB_W'(LONG_LAT - 1)),
            .busy     (pend[r])
        );
    end

    // Saturating stall-cycle monitor
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_c && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.ex_fwd1   = rst_n ? fwd1 : FWD_RF;
    assign bus.ex_fwd2   = rst_n ? fwd2 : FWD_RF;
    assign bus.mem_fwd   = rst_n && mem_fwd_c;
    assign bus.stall     = stall_c;
    assign bus.bubble    = stall_c;
    assign bus.busy      = rst_n ? pend : '0;
    assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: vector table, directed multi-cycle
// sequences and randomized traffic against a timestamp-based scoreboard model.
module tb_hazard_fwd_unit;
    import pipe_pkg::*;

    localparam int unsigned LL = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_fwd_unit_if #(.AW(4), .CNT_W(16)) hif ();
    hazard_fwd_unit_if #(.AW(4), .CNT_W(4))  hif2 ();

    hazard_fwd_unit #(.AW(4), .LONG_LAT(LL), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(hif.slave));
    hazard_fwd_unit #(.AW(4), .LONG_LAT(LL), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(hif2.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a register is busy while the current cycle precedes its ready time
    int cyc = 0;
    int ready_at [16];
    int exp_cnt = 0;
    logic exp_stall = 1'b0;

    typedef struct {
        reg_addr_t id_rs, id_rt;   logic use_rs, use_rt;
        reg_addr_t idex_rs, idex_rt, idex_rd; logic rw, mr, valid;
        reg_addr_t exmem_rd, exmem_rt; logic exmem_rw, exmem_mw;
        reg_addr_t memwb_rd; logic memwb_rw, flush;
        logic [1:0] e_fwd1, e_fwd2; logic e_mem, e_stall;
    } vec_t;
    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        hif.id_rs = '0; hif.id_rt = '0; hif.id_use_rs = 1'b0; hif.id_use_rt = 1'b0;
        hif.idex_rs = '0; hif.idex_rt = '0; hif.idex_rd = '0;
        hif.idex_rw = 1'b0; hif.idex_mr = 1'b0; hif.idex_long = 1'b0; hif.idex_valid = 1'b0;
        hif.exmem_rd = '0; hif.exmem_rt = '0; hif.exmem_rw = 1'b0; hif.exmem_mw = 1'b0;
        hif.memwb_rd = '0; hif.memwb_rw = 1'b0; hif.flush = 1'b0;
    endtask

    task automatic set_long(input reg_addr_t rd);
        hif.idex_valid = 1'b1; hif.idex_long = 1'b1; hif.idex_rw = 1'b1; hif.idex_rd = rd;
    endtask

    function automatic logic [1:0] m_fwd(input reg_addr_t src);
        if (hif.exmem_rw && hif.exmem_rd != 0 && hif.exmem_rd == src) return FWD_MEM;
        if (hif.memwb_rw && hif.memwb_rd != 0 && hif.memwb_rd == src) return FWD_WB;
        return FWD_RF;
    endfunction

    task automatic model_check();
        logic [15:0] eb;
        logic m, es, em;
        logic [1:0] e1, e2;
        for (int r = 0; r < 16; r++) eb[r] = (r != 0) && (cyc < ready_at[r]);
        m  = (hif.id_use_rs && hif.id_rs == hif.idex_rd) || (hif.id_use_rt && hif.id_rt == hif.idex_rd);
        es = !hif.flush && hif.idex_valid && hif.idex_rw && hif.idex_rd != 0
             && (hif.idex_mr || hif.idex_long) && m;
        es = es || (hif.id_use_rs && eb[hif.id_rs]) || (hif.id_use_rt && eb[hif.id_rt]);
        em = hif.exmem_mw && hif.memwb_rw && hif.memwb_rd != 0 && hif.memwb_rd == hif.exmem_rt;
        e1 = m_fwd(hif.idex_rs);
        e2 = m_fwd(hif.idex_rt);
        if (!rst_n) begin
            eb = '0; es = 1'b0; em = 1'b0; e1 = FWD_RF; e2 = FWD_RF;
        end
        exp_stall = es;
        check("m_fwd1",  64'(hif.ex_fwd1),   64'(e1));
        check("m_fwd2",  64'(hif.ex_fwd2),   64'(e2));
        check("m_memfwd", 64'(hif.mem_fwd),  64'(em));
        check("m_stall", 64'(hif.stall),     64'(es));
        check("m_bubble", 64'(hif.bubble),   64'(es));
        check("m_busy",  64'(hif.busy),      64'(eb));
        check("m_cnt",   64'(hif.stall_cnt), 64'(exp_cnt));
    endtask

    // Advance one clock and apply this cycle's effects to the model
    task automatic cyc_end();
        model_check();
        @(posedge clk);
        if (!rst_n) begin
            for (int r = 0; r < 16; r++) ready_at[r] = 0;
            exp_cnt = 0;
        end else begin
            if (exp_stall && exp_cnt < 65535) exp_cnt++;
            if (!hif.flush && hif.idex_valid && hif.idex_long && hif.idex_rw && hif.idex_rd != 0)
                ready_at[hif.idex_rd] = cyc + int'(LL);
        end
        cyc++;
        #1;
    endtask

    initial begin
        for (int r = 0; r < 16; r++) ready_at[r] = 0;
        // id_rs id_rt urs urt | idex rs rt rd rw mr v | exm rd rt rw mw | mwb rd rw fl | f1 f2 mem stall
        vecs[0]  = '{0,0,0,0, 5,0,0, 0,0,0, 5,0,1,0, 5,1,0, 2,0,0,0};
        vecs[1]  = '{0,0,0,0, 5,0,0, 0,0,0, 5,0,0,0, 5,1,0, 1,0,0,0};
        vecs[2]  = '{0,0,0,0, 0,0,0, 0,0,0, 0,0,1,0, 0,1,0, 0,0,0,0};
        vecs[3]  = '{0,0,0,0, 9,9,0, 0,0,0, 9,0,1,0, 9,1,0, 2,2,0,0};
        vecs[4]  = '{0,0,0,0, 2,3,0, 0,0,0, 2,0,0,0, 3,1,0, 0,1,0,0};
        vecs[5]  = '{3,0,1,0, 0,0,3, 1,1,1, 0,0,0,0, 0,0,0, 0,0,0,1};
        vecs[6]  = '{3,0,0,0, 0,0,3, 1,1,1, 0,0,0,0, 0,0,0, 0,0,0,0};
        vecs[7]  = '{0,3,0,1, 0,0,3, 1,1,1, 0,0,0,0, 0,0,0, 0,0,0,1};
        vecs[8]  = '{3,0,1,0, 0,0,3, 1,1,1, 0,0,0,0, 0,0,1, 0,0,0,0};
        vecs[9]  = '{3,0,1,0, 0,0,3, 1,1,0, 0,0,0,0, 0,0,0, 0,0,0,0};
        vecs[10] = '{0,0,1,0, 0,0,0, 1,1,1, 0,0,0,0, 0,0,0, 0,0,0,0};
        vecs[11] = '{0,0,0,0, 0,0,0, 0,0,0, 0,6,0,1, 6,1,0, 0,0,1,0};
        vecs[12] = '{0,0,0,0, 0,0,0, 0,0,0, 0,0,0,1, 0,1,0, 0,0,0,0};
        vecs[13] = '{3,0,1,0, 0,0,3, 0,1,1, 0,0,0,0, 0,0,0, 0,0,0,0};

        // Reset: outputs gated while low, state cleared at the edge
        rst_n = 1'b0;
        drive_idle();
        hif2.id_rs = '0; hif2.id_rt = '0; hif2.id_use_rs = 1'b0; hif2.id_use_rt = 1'b0;
        hif2.idex_rs = '0; hif2.idex_rt = '0; hif2.idex_rd = '0;
        hif2.idex_rw = 1'b0; hif2.idex_mr = 1'b0; hif2.idex_long = 1'b0; hif2.idex_valid = 1'b0;
        hif2.exmem_rd = '0; hif2.exmem_rt = '0; hif2.exmem_rw = 1'b0; hif2.exmem_mw = 1'b0;
        hif2.memwb_rd = '0; hif2.memwb_rw = 1'b0; hif2.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        hif.exmem_rw = 1'b1; hif.exmem_rd = 4'd5; hif.idex_rs = 4'd5;
        hif.idex_valid = 1'b1; hif.idex_mr = 1'b1; hif.idex_rw = 1'b1; hif.idex_rd = 4'd2;
        hif.id_rs = 4'd2; hif.id_use_rs = 1'b1;
        #4;
        check("rst_fwd1",  64'(hif.ex_fwd1), 64'd0);
        check("rst_stall", 64'(hif.stall), 64'd0);
        check("rst_cnt",   64'(hif.stall_cnt), 64'd0);
        check("rst_busy",  64'(hif.busy), 64'd0);
        check("rst_cnt2",  64'(hif2.stall_cnt), 64'd0);
        cyc_end();
        rst_n = 1'b1;
        drive_idle();
        #4; cyc_end();

        // Vector table on a clean scoreboard
        for (int i = 0; i < 14; i++) begin
            hif.id_rs = vecs[i].id_rs; hif.id_rt = vecs[i].id_rt;
            hif.id_use_rs = vecs[i].use_rs; hif.id_use_rt = vecs[i].use_rt;
            hif.idex_rs = vecs[i].idex_rs; hif.idex_rt = vecs[i].idex_rt; hif.idex_rd = vecs[i].idex_rd;
            hif.idex_rw = vecs[i].rw; hif.idex_mr = vecs[i].mr; hif.idex_valid = vecs[i].valid;
            hif.idex_long = 1'b0;
            hif.exmem_rd = vecs[i].exmem_rd; hif.exmem_rt = vecs[i].exmem_rt;
            hif.exmem_rw = vecs[i].exmem_rw; hif.exmem_mw = vecs[i].exmem_mw;
            hif.memwb_rd = vecs[i].memwb_rd; hif.memwb_rw = vecs[i].memwb_rw; hif.flush = vecs[i].flush;
            #4;
            check($sformatf("vec%0d_fwd1", i),  64'(hif.ex_fwd1), 64'(vecs[i].e_fwd1));
            check($sformatf("vec%0d_fwd2", i),  64'(hif.ex_fwd2), 64'(vecs[i].e_fwd2));
            check($sformatf("vec%0d_mem", i),   64'(hif.mem_fwd), 64'(vecs[i].e_mem));
            check($sformatf("vec%0d_stall", i), 64'(hif.stall),   64'(vecs[i].e_stall));
            cyc_end();
        end

        // Long op to r7, consumer in ID stalls through T+2
        drive_idle(); set_long(4'd7); hif.id_rs = 4'd7; hif.id_use_rs = 1'b1;
        #4;
        check("long_t0_stall", 64'(hif.stall), 64'd1);
        check("long_t0_bubble", 64'(hif.bubble), 64'd1);
        cyc_end();
        hif.idex_valid = 1'b0;
        #4;
        check("long_t1_busy", 64'(hif.busy[7]), 64'd1);
        check("long_t1_stall", 64'(hif.stall), 64'd1);
        cyc_end();
        #4;
        check("long_t2_busy", 64'(hif.busy[7]), 64'd1);
        check("long_t2_stall", 64'(hif.stall), 64'd1);
        cyc_end();
        #4;
        check("long_t3_busy", 64'(hif.busy[7]), 64'd0);
        check("long_t3_stall", 64'(hif.stall), 64'd0);
        cyc_end();

        // Reissue on the expiry cycle keeps r7 busy
        drive_idle(); set_long(4'd7);
        #4; cyc_end();
        drive_idle();
        #4; cyc_end();
        set_long(4'd7);
        #4;
        check("reiss_t2_busy", 64'(hif.busy[7]), 64'd1);
        cyc_end();
        drive_idle();
        #4;
        check("reiss_t3_busy", 64'(hif.busy[7]), 64'd1);
        cyc_end();
        #4;
        check("reiss_t4_busy", 64'(hif.busy[7]), 64'd1);
        cyc_end();
        #4;
        check("reiss_t5_busy", 64'(hif.busy[7]), 64'd0);
        cyc_end();

        // Flushed long op never enters the scoreboard
        drive_idle(); set_long(4'd4); hif.flush = 1'b1; hif.id_rs = 4'd4; hif.id_use_rs = 1'b1;
        #4;
        check("flush_stall", 64'(hif.stall), 64'd0);
        cyc_end();
        hif.flush = 1'b0; hif.idex_valid = 1'b0;
        #4;
        check("flush_busy", 64'(hif.busy[4]), 64'd0);
        check("flush_stall2", 64'(hif.stall), 64'd0);
        cyc_end();

        // Reset in the middle of a long op with a nonzero stall count
        rst_n = 1'b0; drive_idle();
        #4; cyc_end();
        rst_n = 1'b1;
        hif.idex_valid = 1'b1; hif.idex_mr = 1'b1; hif.idex_rw = 1'b1; hif.idex_rd = 4'd3;
        hif.id_rs = 4'd3; hif.id_use_rs = 1'b1;
        repeat (8) begin #4; cyc_end(); end
        drive_idle(); set_long(4'd7); hif.id_rs = 4'd7; hif.id_use_rs = 1'b1;
        #4; cyc_end();
        hif.idex_valid = 1'b0;
        #4;
        check("mid_busy7", 64'(hif.busy[7]), 64'd1);
        check("mid_cnt9",  64'(hif.stall_cnt), 64'd9);
        cyc_end();
        rst_n = 1'b0;
        hif.exmem_rw = 1'b1; hif.exmem_rd = 4'd5; hif.idex_rs = 4'd5;
        hif.idex_valid = 1'b1; hif.idex_mr = 1'b1; hif.idex_rw = 1'b1; hif.idex_rd = 4'd7;
        #4;
        check("mid_rst_stall", 64'(hif.stall), 64'd0);
        check("mid_rst_bubble", 64'(hif.bubble), 64'd0);
        check("mid_rst_fwd1", 64'(hif.ex_fwd1), 64'd0);
        check("mid_rst_busy", 64'(hif.busy), 64'd0);
        cyc_end();
        rst_n = 1'b1;
        drive_idle(); hif.id_rs = 4'd7; hif.id_use_rs = 1'b1;
        #4;
        check("post_rst_busy", 64'(hif.busy), 64'd0);
        check("post_rst_cnt", 64'(hif.stall_cnt), 64'd0);
        check("post_rst_stall", 64'(hif.stall), 64'd0);
        cyc_end();

        // Saturation on the 4-bit counter instance
        hif2.idex_valid = 1'b1; hif2.idex_mr = 1'b1; hif2.idex_rw = 1'b1; hif2.idex_rd = 4'd3;
        hif2.id_rs = 4'd3; hif2.id_use_rs = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #4;
            if (i == 3) check("sat_cnt3", 64'(hif2.stall_cnt), 64'd3);
            cyc_end();
        end
        #4;
        check("sat_cnt15", 64'(hif2.stall_cnt), 64'd15);
        check("sat_stall", 64'(hif2.stall), 64'd1);
        cyc_end();
        hif2.idex_valid = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            hif.id_rs = 4'($urandom_range(0, 7));   hif.id_rt = 4'($urandom_range(0, 7));
            hif.id_use_rs = 1'($urandom_range(0, 1)); hif.id_use_rt = 1'($urandom_range(0, 1));
            hif.idex_rs = 4'($urandom_range(0, 7)); hif.idex_rt = 4'($urandom_range(0, 7));
            hif.idex_rd = 4'($urandom_range(0, 7));
            hif.idex_valid = ($urandom_range(0, 99) < 75);
            hif.idex_rw = ($urandom_range(0, 99) < 70);
            hif.idex_mr = ($urandom_range(0, 99) < 25);
            hif.idex_long = ($urandom_range(0, 99) < 15);
            hif.exmem_rd = 4'($urandom_range(0, 7)); hif.exmem_rt = 4'($urandom_range(0, 7));
            hif.exmem_rw = 1'($urandom_range(0, 1)); hif.exmem_mw = 1'($urandom_range(0, 1));
            hif.memwb_rd = 4'($urandom_range(0, 7)); hif.memwb_rw = 1'($urandom_range(0, 1));
            hif.flush = ($urandom_range(0, 99) < 10);
            rst_n = ($urandom_range(0, 49) != 0);
            #4;
            cyc_end();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
